// File: rtl/sample_serializer_pkg.sv
// Shared constants and types for the IADC sample serializer.
package iadc_pkg;

   localparam int IADC_DATA_W = 12;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;

endpackage

// File: rtl/sample_serializer_if.sv
// Sample bus from the decimator plus the 3-wire serial link and status of the serializer.
interface sample_serializer_if
   import iadc_pkg::*;
#(
   parameter int DATA_W     = IADC_DATA_W,
   parameter int FIFO_DEPTH = 4
);

   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

   logic [DATA_W-1:0] data_in;
   logic              new_data;
   logic              ovf_clr;
   logic              sclk_out;
   logic              sdata_out;
   logic              frame_out;
   logic              overflow;
   logic [LVL_W-1:0]  fifo_level;

   modport master (
      output data_in, new_data, ovf_clr,
      input  sclk_out, sdata_out, frame_out, overflow, fifo_level
   );

   modport slave (
      input  data_in, new_data, ovf_clr,
      output sclk_out, sdata_out, frame_out, overflow, fifo_level
   );

endinterface

// File: rtl/sample_serializer_fifo.sv
// Synchronous sample FIFO; a write on a full FIFO is accepted when a read frees the slot in the same cycle.
module sample_fifo #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 4,
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level
);

   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_wr;
   logic              do_rd;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         if (do_wr && !do_rd)      level <= level + 1'b1;
         else if (do_rd && !do_wr) level <= level - 1'b1;
      end
   end

endmodule

// File: rtl/sample_serializer.sv
// Buffers decimated samples and shifts them MSB-first on sclk/sdata/frame with a sticky overflow flag.
// Define PARITY_EN to append an even-parity bit after the LSB of every word.
module sample_serializer
   import iadc_pkg::*;
#(
   parameter int DATA_W     = IADC_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 4
) (
   input logic                clk,
   input logic                rst_n,
   sample_serializer_if.slave bus
);

`ifdef PARITY_EN
   localparam int NBITS = DATA_W + 1;
`else
   localparam int NBITS = DATA_W;
`endif
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(NBITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CLK_DIV - 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

   logic [1:0]        rst_sync;
   logic              rst_int_n;
   ser_state_t        state;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [NBITS-1:0]  shreg;
   logic [NBITS-1:0]  load_word;
   logic [DATA_W-1:0] head;
   logic              full;
   logic              empty;
   logic [LVL_W-1:0]  level;
   logic              pop;
   logic              push;
   logic              drop;
   logic              sclk_q;
   logic              sdata_q;
   logic              frame_q;
   logic              ovf_q;

   // Asynchronous assertion, release synchronised to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   assign pop  = (state == IDLE) && !empty;
   assign push = bus.new_data && (!full || pop);
   assign drop = bus.new_data && !push;

`ifdef PARITY_EN
   assign load_word = {head, ^head};
`else
   assign load_word = head;
`endif

   sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .wr_en   (push),
      .wr_data (bus.data_in),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // The IDLE pop cycle is one of the CLK_DIV quiet cycles, so GAP holds one fewer
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         sclk_q  <= 1'b0;
         sdata_q <= 1'b0;
         frame_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (drop)             ovf_q <= 1'b1;
         else if (bus.ovf_clr) ovf_q <= 1'b0;

         case (state)
            IDLE: begin
               sclk_q  <= 1'b0;
               sdata_q <= 1'b0;
               frame_q <= 1'b0;
               if (pop) begin
                  shreg   <= load_word;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               frame_q <= 1'b1;
               sclk_q  <= (div_cnt >= DIV_HALF);
               sdata_q <= shreg[NBITS-1];
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  shreg   <= {shreg[NBITS-2:0], 1'b0};
                  if (bit_cnt == BIT_LAST) state <= GAP;
                  else                     bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            GAP: begin
               sclk_q  <= 1'b0;
               sdata_q <= 1'b0;
               frame_q <= 1'b0;
               if (div_cnt == GAP_LAST) begin
                  div_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sclk_out   = sclk_q;
   assign bus.sdata_out  = sdata_q;
   assign bus.frame_out  = frame_q;
   assign bus.overflow   = ovf_q;
   assign bus.fifo_level = level;

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer (DATA_W=12, FIFO_DEPTH=4, CLK_DIV=4); honours PARITY_EN.
module tb_sample_serializer;

   localparam int DATA_W     = 12;
   localparam int FIFO_DEPTH = 4;
   localparam int CLK_DIV    = 4;

`ifdef PARITY_EN
   localparam int               NB      = 13;
   localparam logic [15:0]      EXP_A5C = 16'h14B8;
   localparam logic [15:0]      EXP_B2B [5] = '{16'h0003, 16'h0005, 16'h0006, 16'h0009, 16'h000A};
   localparam logic [15:0]      EXP_SPC [3] = '{16'h0000, 16'h1FFE, 16'h1001};
`else
   localparam int               NB      = 12;
   localparam logic [15:0]      EXP_A5C = 16'h0A5C;
   localparam logic [15:0]      EXP_B2B [5] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
   localparam logic [15:0]      EXP_SPC [3] = '{16'h0000, 16'h0FFF, 16'h0800};
`endif
   localparam logic [11:0] SPC_VAL [3] = '{12'h000, 12'hFFF, 12'h800};

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sample_serializer_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

   sample_serializer #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CLK_DIV    (CLK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] word;
      int          nbits;
      int          len;
      int          gap;
   } frm_t;

   frm_t        q[$];
   logic        prev_sclk  = 1'b0;
   logic        prev_frame = 1'b0;
   logic [15:0] m_word     = '0;
   int          m_nb       = 0;
   int          m_len      = 0;
   int          m_gap      = 0;
   int          m_low      = 0;

   // Link receiver: samples sdata on sclk rises, records frame length and the quiet gap before it
   always @(negedge clk) begin
      prev_sclk  <= bus.sclk_out;
      prev_frame <= bus.frame_out;
      if (bus.frame_out) begin
         if (!prev_frame) begin
            m_len  <= 1;
            m_gap  <= m_low;
            m_word <= '0;
            m_nb   <= 0;
         end else begin
            m_len <= m_len + 1;
         end
         if (bus.sclk_out && !prev_sclk) begin
            m_word <= {m_word[14:0], bus.sdata_out};
            m_nb   <= m_nb + 1;
         end
      end else begin
         if (prev_frame) begin
            q.push_back('{m_word, m_nb, m_len, m_gap});
            m_low <= 1;
         end else begin
            m_low <= m_low + 1;
         end
      end
   end

   int   total = 0;
   int   bad   = 0;
   int   max_lvl = 0;
   frm_t f;

   task automatic step();
      @(posedge clk);
      #1;
      if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
   endtask

   task automatic push(input logic [11:0] v);
      bus.data_in  = v;
      bus.new_data = 1'b1;
      step();
      bus.new_data = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget, input string tag);
      int cnt = 0;
      while (q.size() < n && cnt < budget) begin
         step();
         cnt++;
      end
      total++;
      if (q.size() < n) begin
         bad++;
         $display("FAIL %s_timeout frames=%0d required=%0d", tag, q.size(), n);
      end
   endtask

   task automatic test_reset();
      bit seen_frame;
      bus.data_in  = '0;
      bus.new_data = 1'b0;
      bus.ovf_clr  = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.frame_out, bus.sclk_out, bus.sdata_out, bus.overflow, bus.fifo_level} !== 7'b0) begin
         bad++;
         $display("FAIL reset_initial outputs=%b required=0", {bus.frame_out, bus.sclk_out, bus.sdata_out, bus.overflow, bus.fifo_level});
      end
      repeat (3) step();
      rst_n = 1'b1;
      repeat (4) step();
      total++;
      if ({bus.frame_out, bus.overflow, bus.fifo_level} !== 5'b0) begin
         bad++;
         $display("FAIL reset_release outputs=%b required=0", {bus.frame_out, bus.overflow, bus.fifo_level});
      end
      push(12'hA5C);
      repeat (20) step();
      total++;
      if (bus.frame_out !== 1'b1) begin
         bad++;
         $display("FAIL reset_midword_frame got=%b required=1", bus.frame_out);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.frame_out, bus.sclk_out, bus.sdata_out, bus.overflow, bus.fifo_level} !== 7'b0) begin
         bad++;
         $display("FAIL reset_async outputs=%b required=0", {bus.frame_out, bus.sclk_out, bus.sdata_out, bus.overflow, bus.fifo_level});
      end
      step();
      q.delete();
      repeat (2) step();
      rst_n = 1'b1;
      seen_frame = 1'b0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (bus.frame_out) seen_frame = 1'b1;
      end
      total++;
      if (seen_frame || q.size() != 0) begin
         bad++;
         $display("FAIL reset_no_frame seen=%b frames=%0d required=0", seen_frame, q.size());
      end
   endtask

   task automatic test_single();
      push(12'hA5C);
      total++;
      if (bus.fifo_level !== 3'd1) begin
         bad++;
         $display("FAIL single_level_push got=%0d required=1", bus.fifo_level);
      end
      step();
      total++;
      if (bus.fifo_level !== 3'd0 || bus.frame_out !== 1'b0) begin
         bad++;
         $display("FAIL single_pop level=%0d frame=%b required level=0 frame=0", bus.fifo_level, bus.frame_out);
      end
      step();
      total++;
      if (bus.frame_out !== 1'b1 || bus.sclk_out !== 1'b0 || bus.sdata_out !== 1'b1) begin
         bad++;
         $display("FAIL single_frame_rise frame=%b sclk=%b sdata=%b required 1 0 1", bus.frame_out, bus.sclk_out, bus.sdata_out);
      end
      wait_frames(1, 200, "single");
      if (q.size() > 0) begin
         f = q.pop_front();
         total++;
         if (f.word !== EXP_A5C || f.nbits != NB) begin
            bad++;
            $display("FAIL single_word got=%h/%0d required=%h/%0d", f.word, f.nbits, EXP_A5C, NB);
         end
         total++;
         if (f.len != NB * CLK_DIV) begin
            bad++;
            $display("FAIL single_len got=%0d required=%0d", f.len, NB * CLK_DIV);
         end
      end
      repeat (4) step();
      total++;
      if (bus.frame_out !== 1'b0 || bus.fifo_level !== 3'd0 || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL single_after frame=%b level=%0d ovf=%b required 0 0 0", bus.frame_out, bus.fifo_level, bus.overflow);
      end
   endtask

   task automatic test_back_to_back();
      max_lvl = 0;
      for (int i = 1; i <= 6; i++) push(12'(i));
      total++;
      if (bus.overflow !== 1'b1) begin
         bad++;
         $display("FAIL b2b_overflow got=%b required=1", bus.overflow);
      end
      wait_frames(5, 600, "b2b");
      total++;
      if (max_lvl != 4) begin
         bad++;
         $display("FAIL b2b_peak_level got=%0d required=4", max_lvl);
      end
      for (int k = 0; k < 5; k++) begin
         if (q.size() > 0) begin
            f = q.pop_front();
            total++;
            if (f.word !== EXP_B2B[k] || f.nbits != NB || f.len != NB * CLK_DIV) begin
               bad++;
               $display("FAIL b2b_word%0d got=%h/%0d/%0d required=%h/%0d/%0d", k, f.word, f.nbits, f.len, EXP_B2B[k], NB, NB * CLK_DIV);
            end
            if (k > 0) begin
               total++;
               if (f.gap != CLK_DIV) begin
                  bad++;
                  $display("FAIL b2b_gap%0d got=%0d required=%0d", k, f.gap, CLK_DIV);
               end
            end
         end
      end
      repeat (60) step();
      total++;
      if (q.size() != 0 || bus.fifo_level !== 3'd0) begin
         bad++;
         $display("FAIL b2b_no_extra frames=%0d level=%0d required 0 0", q.size(), bus.fifo_level);
      end
   endtask

   task automatic test_ovf_clr();
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      total++;
      if (bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear got=%b required=0", bus.overflow);
      end
      for (int i = 1; i <= 5; i++) push(12'(16 + i));
      total++;
      if (bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_fill got=%b required=0", bus.overflow);
      end
      bus.ovf_clr = 1'b1;
      push(12'h0EE);
      bus.ovf_clr = 1'b0;
      total++;
      if (bus.overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_drop_with_clr got=%b required=1", bus.overflow);
      end
      step();
      total++;
      if (bus.overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_sticky got=%b required=1", bus.overflow);
      end
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      total++;
      if (bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear2 got=%b required=0", bus.overflow);
      end
      wait_frames(5, 600, "ovf_drain");
      q.delete();
      repeat (10) step();
   endtask

   task automatic test_spaced();
      max_lvl = 0;
      for (int k = 0; k < 3; k++) begin
         push(SPC_VAL[k]);
         repeat (63) step();
      end
      wait_frames(3, 200, "spaced");
      for (int k = 0; k < 3; k++) begin
         if (q.size() > 0) begin
            f = q.pop_front();
            total++;
            if (f.word !== EXP_SPC[k] || f.nbits != NB || f.len != NB * CLK_DIV) begin
               bad++;
               $display("FAIL spaced_word%0d got=%h/%0d/%0d required=%h/%0d/%0d", k, f.word, f.nbits, f.len, EXP_SPC[k], NB, NB * CLK_DIV);
            end
         end
      end
      total++;
      if (bus.overflow !== 1'b0 || max_lvl != 1) begin
         bad++;
         $display("FAIL spaced_status ovf=%b peak=%0d required ovf=0 peak=1", bus.overflow, max_lvl);
      end
   endtask

`ifdef PARITY_EN
   task automatic test_parity();
      push(12'h001);
      wait_frames(1, 200, "parity");
      if (q.size() > 0) begin
         f = q.pop_front();
         total++;
         if (f.word !== 16'h0003 || f.nbits != 13 || f.len != 52) begin
            bad++;
            $display("FAIL parity_001 got=%h/%0d/%0d required=0003/13/52", f.word, f.nbits, f.len);
         end
      end
      repeat (8) step();
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ovf_clr();
      test_spaced();
`ifdef PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
